ranc_output_axis_tx: RTL and testbench
======================================

RANC_OUTPUT_AXIS_TX -- requirements
Module: ranc_output_axis_tx

Interface
REQ-001 SHALL have parameter NUM_OUTPUTS, default 256: number of output-core spike indices; index width OW = $clog2(NUM_OUTPUTS).
REQ-002 SHALL have parameter OUTPUT_FIFO_DEPTH, default 512: entries in the spike FIFO; power of two, at least 4.
REQ-003 SHALL have parameter C_M00_AXIS_TDATA_WIDTH, default 32: AXIS data width, fixed at 32.
REQ-004 SHALL use a single clock, clk; all state on its rising edge.
REQ-005 port clk  input  1  system clock; SHALL be the only clock.
REQ-006 port rst  input  1  asynchronous, active-high reset.
REQ-007 port tick  input  1  one-cycle pulse marking the end of the current RANC tick.
REQ-008 port packet_out  input  OW  output-neuron index from the network grid.
REQ-009 port packet_out_valid  input  1  packet_out qualifier, one spike per cycle.
REQ-010 port m00_axis_tvalid  output  1  AXIS master valid.
REQ-011 port m00_axis_tdata  output  32  AXIS master data.
REQ-012 port m00_axis_tstrb  output  4  byte strobes, constant 4'hF.
REQ-013 port m00_axis_tlast  output  1  end-of-tick frame marker.
REQ-014 port m00_axis_tready  input  1  AXIS slave ready.
REQ-015 port overflow_error  output  1  sticky; a spike or marker was dropped.
REQ-016 port fifo_count  output  $clog2(OUTPUT_FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Spike word: tdata[31]=0, tdata[30:OW]=0, tdata[OW-1:0]=packet_out; tlast=0.
REQ-018 Marker word, pushed once per tick pulse: tdata[31]=1, [30:16]=spikes dropped during this tick (saturate 0x7FFF), [15:0]=tick_count; tlast=1.
REQ-019 tick_count: 16-bit, increments after each marker push attempt (whether written or not), wraps 0xFFFF->0x0000.
REQ-020 FIFO SHALL accept up to two writes per cycle; with tick and packet_out_valid together, spike is written before the marker, and the spike counts toward that marker's frame.
REQ-021 Free slots = DEPTH - fifo_count. 0 free: all writes that cycle dropped. 1 free with both pending: marker written, spike dropped.
REQ-022 A dropped spike SHALL increment the per-tick drop counter and set overflow_error; a dropped marker SHALL set overflow_error only.
REQ-023 Per-tick drop counter SHALL clear after each marker push attempt; a spike dropped in the same cycle as tick counts toward the closing marker.
REQ-024 Output is first-word-fall-through: m00_axis_tvalid = FIFO non-empty; tdata/tlast = head entry.
REQ-025 Write-to-output latency: entry written at edge N SHALL be visible on the AXIS outputs after edge N when the FIFO was empty (one cycle).
REQ-026 Transfer occurs when tvalid & tready; head pops on that edge. While tvalid=1 and tready=0, tdata/tlast SHALL stay stable.
REQ-027 Simultaneous pop and push(es) SHALL be legal; fifo_count changes by (writes - pop); free slots are computed before the pop.
REQ-028 Read/write pointers SHALL wrap modulo OUTPUT_FIFO_DEPTH; fifo_count SHALL never exceed DEPTH.
REQ-029 overflow_error SHALL remain 1 until rst.
REQ-030 packet_out SHALL be ignored when packet_out_valid=0.

Reset
REQ-031 rst=1 SHALL immediately clear pointers, fifo_count=0, tick_count=0, drop counter=0, overflow_error=0, m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0.
REQ-032 Reset mid-frame SHALL discard all queued words; the first marker after reset carries tick_count 0.
REQ-033 tick and packet_out_valid SHALL be ignored while rst=1.

Verification
REQ-034 tready=1; spikes 5, 17, 200, then tick -> words 0x00000005, 0x00000011, 0x000000C8, then 0x80000000 with tlast=1.
REQ-035 tick with no spikes, three times -> 0x80000000, 0x80000001, 0x80000002, each tlast=1.
REQ-036 tick and packet_out_valid (index 9) in the same cycle -> 0x00000009 then marker, marker follows spike.
REQ-037 DEPTH=4, tready=0, 6 spikes then tick -> 4 spikes stored, overflow_error=1, marker dropped; after release, next tick's marker tdata[30:16]=0.
REQ-038 DEPTH=4, tready=0, 3 spikes, then spike+tick together -> marker stored, 4th spike dropped; marker tdata[30:16]=1.
REQ-039 tready toggled randomly over 1000 spikes -> no loss, order preserved, tdata stable while stalled; rst asserted mid-frame -> tvalid=0 immediately, next marker tick_count=0.

Source files
------------

// File: rtl/ranc_output_axis_tx.sv
// RANC output stage: queues output-core spikes and per-tick marker words in a
// FIFO and streams them out as a first-word-fall-through AXI4-Stream master.
module ranc_output_axis_tx #(
    parameter int NUM_OUTPUTS            = 256,
    parameter int OUTPUT_FIFO_DEPTH      = 512,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    localparam int OW = $clog2(NUM_OUTPUTS),
    localparam int CW = $clog2(OUTPUT_FIFO_DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              tick,
    input  logic [OW-1:0]                     packet_out,
    input  logic                              packet_out_valid,
    output logic                              m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic [3:0]                        m00_axis_tstrb,
    output logic                              m00_axis_tlast,
    input  logic                              m00_axis_tready,
    output logic                              overflow_error,
    output logic [CW-1:0]                     fifo_count
);

    localparam int AW = $clog2(OUTPUT_FIFO_DEPTH);
    localparam int DW = C_M00_AXIS_TDATA_WIDTH;

    // Each entry carries tlast in its top bit above the data word.
    logic [DW:0]     mem_q [OUTPUT_FIFO_DEPTH];
    logic [AW-1:0]   rdPtr_q, rdPtr_d;
    logic [AW-1:0]   wrPtr_q, wrPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     tickCnt_q, tickCnt_d;
    logic [14:0]     dropCnt_q, dropCnt_d;
    logic            ovf_q, ovf_d;

    logic [CW-1:0]   freeSlots;
    logic            pop;
    logic            spikeWr;
    logic            markWr;
    logic            spikeDrop;
    logic [14:0]     dropTotal;
    logic [DW:0]     spikeWord;
    logic [DW:0]     markWord;
    logic [AW-1:0]   markAddr;
    logic [DW:0]     headWord;

    always_comb begin
        freeSlots = CW'(OUTPUT_FIFO_DEPTH) - count_q;
        pop       = (count_q != '0) && m00_axis_tready;

        // With a single free slot and both writes pending, the marker wins.
        spikeWr   = packet_out_valid &&
                    ((freeSlots >= CW'(2)) || ((freeSlots == CW'(1)) && !tick));
        markWr    = tick && (freeSlots != '0);
        spikeDrop = packet_out_valid && !spikeWr;

        dropTotal = dropCnt_q;
        if (spikeDrop && (dropCnt_q != 15'h7FFF)) begin
            dropTotal = dropCnt_q + 15'd1;
        end

        spikeWord             = '0;
        spikeWord[OW-1:0]     = packet_out;

        markWord              = '0;
        markWord[DW]          = 1'b1;
        markWord[31]          = 1'b1;
        markWord[30:16]       = dropTotal;
        markWord[15:0]        = tickCnt_q;

        markAddr  = spikeWr ? (wrPtr_q + AW'(1)) : wrPtr_q;

        wrPtr_d   = wrPtr_q + AW'(spikeWr) + AW'(markWr);
        rdPtr_d   = rdPtr_q + AW'(pop);
        count_d   = count_q + CW'(spikeWr) + CW'(markWr) - CW'(pop);
        ovf_d     = ovf_q | spikeDrop | (tick && !markWr);
        dropCnt_d = tick ? 15'd0 : dropTotal;
        tickCnt_d = tickCnt_q + 16'(tick);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
            tickCnt_q <= '0;
            dropCnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            count_q   <= count_d;
            tickCnt_q <= tickCnt_d;
            dropCnt_q <= dropCnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage needs no reset: the cleared pointers make stale contents invisible.
    always_ff @(posedge clk) begin
        if (spikeWr) begin
            mem_q[wrPtr_q] <= spikeWord;
        end
        if (markWr) begin
            mem_q[markAddr] <= markWord;
        end
    end

    assign headWord        = mem_q[rdPtr_q];
    assign m00_axis_tvalid = (count_q != '0);
    assign m00_axis_tdata  = m00_axis_tvalid ? headWord[DW-1:0] : '0;
    assign m00_axis_tlast  = m00_axis_tvalid & headWord[DW];
    assign m00_axis_tstrb  = 4'hF;
    assign overflow_error  = ovf_q;
    assign fifo_count      = count_q;

endmodule

// File: tb/tb_ranc_output_axis_tx.sv
// Scoreboard bench for ranc_output_axis_tx with a 4-entry FIFO so that
// overflow and marker-priority corner cases are easy to reach.
module tb_ranc_output_axis_tx;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [7:0]    packet_out = '0;
    logic          packet_out_valid = 1'b0;
    logic          m00_axis_tvalid;
    logic [31:0]   m00_axis_tdata;
    logic [3:0]    m00_axis_tstrb;
    logic          m00_axis_tlast;
    logic          m00_axis_tready = 1'b0;
    logic          overflow_error;
    logic [CW-1:0] fifo_count;

    int checks = 0;
    int fails  = 0;

    // Reference model: expected FIFO contents plus tick/drop/overflow state.
    logic [32:0] q[$];
    int          mTick = 0;
    int          mDrop = 0;
    bit          mOvf  = 1'b0;

    ranc_output_axis_tx #(
        .NUM_OUTPUTS(256),
        .OUTPUT_FIFO_DEPTH(DEPTH),
        .C_M00_AXIS_TDATA_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .packet_out(packet_out),
        .packet_out_valid(packet_out_valid),
        .m00_axis_tvalid(m00_axis_tvalid),
        .m00_axis_tdata(m00_axis_tdata),
        .m00_axis_tstrb(m00_axis_tstrb),
        .m00_axis_tlast(m00_axis_tlast),
        .m00_axis_tready(m00_axis_tready),
        .overflow_error(overflow_error),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check outputs produced by the last edge, then drive this
    // cycle's inputs and advance the model exactly as the next edge should.
    task automatic applyStimulus(input bit tk, input bit pv, input logic [7:0] idx, input bit rdy);
        int          sz;
        int          free;
        bit          sW;
        bit          mW;
        logic [32:0] w;
        @(negedge clk);
        sz = q.size();
        checkOutput("tvalid", m00_axis_tvalid, sz > 0);
        checkOutput("fifo_count", fifo_count, sz);
        checkOutput("overflow_error", overflow_error, mOvf);
        checkOutput("tstrb", m00_axis_tstrb, 4'hF);
        if (sz > 0) begin
            checkOutput("tdata", m00_axis_tdata, q[0][31:0]);
            checkOutput("tlast", m00_axis_tlast, q[0][32]);
        end
        tick             = tk;
        packet_out_valid = pv;
        packet_out       = idx;
        m00_axis_tready  = rdy;
        free = DEPTH - sz;
        sW = pv && ((free >= 2) || (free == 1 && !tk));
        mW = tk && (free >= 1);
        if (rdy && sz > 0) void'(q.pop_front());
        if (sW) q.push_back({1'b0, 24'h0, idx});
        if (pv && !sW) begin
            mOvf = 1'b1;
            if (mDrop < 32'h7FFF) mDrop++;
        end
        if (tk) begin
            w = {1'b1, 1'b1, mDrop[14:0], mTick[15:0]};
            if (mW) q.push_back(w);
            else mOvf = 1'b1;
            mTick = (mTick + 1) & 32'hFFFF;
            mDrop = 0;
        end
    endtask

    task automatic idleCycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, rdy);
    endtask

    // Reset is raised between edges so its asynchronous effect can be checked.
    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        tick = 1'b0;
        packet_out_valid = 1'b0;
        #1;
        checkOutput("rst_tvalid", m00_axis_tvalid, 1'b0);
        checkOutput("rst_tdata", m00_axis_tdata, 32'h0);
        checkOutput("rst_tlast", m00_axis_tlast, 1'b0);
        checkOutput("rst_fifo_count", fifo_count, 0);
        checkOutput("rst_overflow", overflow_error, 1'b0);
        q.delete();
        mTick = 0;
        mDrop = 0;
        mOvf  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int spikes;
        $display("[TB] start");
        applyReset();

        // Three spikes then a tick, free-flowing sink.
        applyStimulus(1'b0, 1'b1, 8'd5, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd17, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'd200, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
        idleCycles(4, 1'b1);

        // Ticks with no spikes, from a fresh tick counter.
        applyReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
            idleCycles(2, 1'b1);
        end

        // Spike and tick in the same cycle: spike precedes marker.
        applyStimulus(1'b1, 1'b1, 8'd9, 1'b1);
        idleCycles(4, 1'b1);

        // Stalled sink, six spikes then tick: four stored, marker dropped.
        applyReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 8'(10 + i), 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        idleCycles(3, 1'b0);
        idleCycles(6, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
        idleCycles(3, 1'b1);

        // Three spikes then spike+tick with one free slot: marker wins.
        applyReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'(40 + i), 1'b0);
        applyStimulus(1'b1, 1'b1, 8'd43, 1'b0);
        idleCycles(2, 1'b0);
        idleCycles(6, 1'b1);

        // Random backpressure with occasional ticks.
        applyReset();
        spikes = 0;
        while (spikes < 1000) begin
            bit pv;
            pv = ($urandom_range(0, 99) < 60);
            if (pv) spikes++;
            applyStimulus(($urandom_range(0, 39) == 0), pv, 8'($urandom_range(0, 255)),
                          ($urandom_range(0, 1) == 1));
        end

        // Reset while words are still queued, then the first marker.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'(i + 1), 1'b0);
        applyReset();
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b1);
        idleCycles(3, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
